// File: rtl/master_bridge_aw_splitter_if.sv
// -----------------------------------------------------------------------------
// master_bridge_aw_splitter_if
// Bus bundle between the TL RX request decoder, the AW splitter and the write
// side of the master bridge async FIFO.
//
// Signals:
//   req_valid / req_ready  request handshake
//   req_addr               start byte address (DW aligned)
//   req_len                length in DW, 0 encodes 1024
//   wr_full                async FIFO full
//   wr_inc                 push strobe into the async FIFO
//   wr_data                burst descriptor {addr, len[7:0], size[2:0], burst[1:0]}
//
// Modports:
//   master  the splitter (accepts requests, pushes descriptors)
//   slave   the surroundings (issues requests, reports FIFO full)
// -----------------------------------------------------------------------------
interface master_bridge_aw_splitter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int ENTRY_WIDTH = ADDR_WIDTH + 13
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [9:0]             req_len;
  logic                   wr_full;
  logic                   wr_inc;
  logic [ENTRY_WIDTH-1:0] wr_data;

  modport master (
    input  req_valid, req_addr, req_len, wr_full,
    output req_ready, wr_inc, wr_data
  );

  modport slave (
    output req_valid, req_addr, req_len, wr_full,
    input  req_ready, wr_inc, wr_data
  );
endinterface

// File: rtl/master_bridge_aw_splitter.sv
// -----------------------------------------------------------------------------
// master_bridge_aw_splitter
// Breaks one decoded memory-write request (start address + DW length) into
// AXI4 INCR write-address bursts that never cross a 4 KB page and never exceed
// MAX_BEATS beats, and pushes each burst descriptor into the async FIFO.
//
// Ports:
//   CLK             single clock (write side of the master bridge)
//   RST             synchronous, active-high reset
//   bus             request handshake + FIFO push interface (master modport)
//   busy            a request is being split
//   stat_burst_cnt  saturating count of pushed bursts
//
// Optional feature:
//   MB_AW_SPLIT_STATS_EN  when defined, stat_burst_cnt counts pushes and
//                         saturates at 16'hFFFF; otherwise it is tied to 0.
//
// Each burst takes a CALC cycle (segment arithmetic, descriptor registered)
// followed by a PUSH cycle that holds the descriptor until the FIFO takes it.
// -----------------------------------------------------------------------------
module master_bridge_aw_splitter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int BEAT_BYTES_LOG2 = 5,
  parameter int MAX_BEATS       = 16,
  parameter int ENTRY_WIDTH     = ADDR_WIDTH + 13
) (
  input  logic                        CLK,
  input  logic                        RST,
  master_bridge_aw_splitter_if.master bus,
  output logic                        busy,
  output logic [15:0]                 stat_burst_cnt
);

  localparam int L = BEAT_BYTES_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  cur_addr, end_addr, next_addr;
  logic                   last_seg;
  logic [ENTRY_WIDTH-1:0] wr_data_q;

  logic                   accept, push;
  logic [ADDR_WIDTH-1:0]  len_bytes, bnd_end, cap_end, seg_end;
  logic [7:0]             seg_len;

  assign accept = bus.req_valid && (state == IDLE);
  assign push   = (state == PUSH) && !bus.wr_full;

  // A zero length field means a full 1024-DW (4 KB) request.
  assign len_bytes = (bus.req_len == 10'd0) ? ADDR_WIDTH'(4096)
                                            : ADDR_WIDTH'({bus.req_len, 2'b00});

  // Last byte of the current 4 KB page and last byte reachable in MAX_BEATS
  // beats counted from the beat that contains cur_addr.
  assign bnd_end = {cur_addr[ADDR_WIDTH-1:12], 12'hFFF};
  assign cap_end = (((cur_addr >> L) + ADDR_WIDTH'(MAX_BEATS)) << L) - ADDR_WIDTH'(1);

  always_comb begin
    seg_end = end_addr;
    if (bnd_end < seg_end) seg_end = bnd_end;
    if (cap_end < seg_end) seg_end = cap_end;
  end

  // beats-1 is at most MAX_BEATS-1, so the AXI len field always fits.
  assign seg_len = 8'((seg_end >> L) - (cur_addr >> L));

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/output logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.wr_inc    = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (accept) state_next = CALC;
      end
      CALC: state_next = PUSH;
      PUSH: begin
        bus.wr_inc = !bus.wr_full;
        if (push) state_next = last_seg ? IDLE : CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address walk and descriptor register
  // ---------------------------------------------------------------------------
  // NOTE: wr_data is visible at the port and must read 0 out of reset; the
  // remaining walk registers are reset alongside it so a reset mid-request
  // leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_addr  <= '0;
      end_addr  <= '0;
      next_addr <= '0;
      last_seg  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      if (accept) begin
        cur_addr <= bus.req_addr;
        end_addr <= bus.req_addr + len_bytes - ADDR_WIDTH'(1);
      end
      if (state == CALC) begin
        wr_data_q <= {cur_addr, seg_len, 3'(L), 2'b01};
        last_seg  <= (seg_end == end_addr);
        next_addr <= seg_end + ADDR_WIDTH'(1);
      end
      if (push && !last_seg) cur_addr <= next_addr;
    end
  end

  assign bus.wr_data = wr_data_q;

  // ---------------------------------------------------------------------------
  // Burst statistics
  // ---------------------------------------------------------------------------
`ifdef MB_AW_SPLIT_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge CLK) begin
    if (RST)                            stat_q <= 16'd0;
    else if (push && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end

  assign stat_burst_cnt = stat_q;
`else
  assign stat_burst_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_master_bridge_aw_splitter.sv
// -----------------------------------------------------------------------------
// tb_master_bridge_aw_splitter
// Directed bench for master_bridge_aw_splitter. A beat-walking reference model
// turns each request into the expected descriptor list; a compare process
// checks every push, the stats counter and busy/req_ready on each negedge.
// Scenario code adds latency, spacing, backpressure, reset and literal checks.
// -----------------------------------------------------------------------------
module tb_master_bridge_aw_splitter;
  localparam int AW = 64;
  localparam int L  = 5;
  localparam int MB = 16;
  localparam int EW = AW + 13;

`ifdef MB_AW_SPLIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        busy;
  logic [15:0] stat_burst_cnt;

  master_bridge_aw_splitter_if #(.ADDR_WIDTH(AW)) bus ();

  master_bridge_aw_splitter #(
    .ADDR_WIDTH(AW), .BEAT_BYTES_LOG2(L), .MAX_BEATS(MB)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .busy(busy), .stat_burst_cnt(stat_burst_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: walk the request beat by beat and close a burst whenever
  // it already holds MB beats or the next beat lies in another 4 KB page.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] desc(input logic [AW-1:0] a, input int beats);
    return {a, 8'(beats - 1), 3'(L), 2'b01};
  endfunction

  task automatic model_request(input logic [AW-1:0] addr, input int len);
    longint unsigned nbytes, last_byte, first_beat, last_beat;
    logic [AW-1:0]   b_addr;
    int              cnt;
    nbytes     = (len == 0) ? 4096 : longint'(len) * 4;
    last_byte  = addr + nbytes - 1;
    first_beat = addr >> L;
    last_beat  = last_byte >> L;
    b_addr     = addr;
    cnt        = 0;
    for (longint unsigned b = first_beat; b <= last_beat; b++) begin
      if (cnt == MB || (cnt > 0 && ((b << L) >> 12) != (b_addr >> 12))) begin
        exp_q.push_back(desc(b_addr, cnt));
        b_addr = b << L;
        cnt    = 0;
      end
      cnt++;
    end
    exp_q.push_back(desc(b_addr, cnt));
  endtask

  // ---------------------------------------------------------------------------
  // Cycle counter and compare process
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            model_cnt = 0;
  int            push_cnt = 0;
  int            push_cyc[$];
  logic [EW-1:0] push_data[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST) begin
      model_cnt = 0;
    end else begin
      check("busy_vs_ready", busy, !bus.req_ready);
      check("stat_cnt", stat_burst_cnt, STATS ? model_cnt : 0);
      if (bus.wr_inc) begin
        check("push_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("push_desc", bus.wr_data, exp_q.pop_front());
        push_cnt++;
        push_cyc.push_back(cyc);
        push_data.push_back(bus.wr_data);
        if (model_cnt != 65535) model_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after a clock edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [AW-1:0] a, input logic [9:0] len, output int acc);
    int n;
    n = 0;
    model_request(a, int'(len));
    while (!bus.req_ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    acc = cyc + 1;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_pushes(input int target, input string name);
    int n;
    n = 0;
    while (push_cnt < target && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    check(name, push_cnt, target);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int acc, base, rel_cyc;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_full   = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_wr_inc", bus.wr_inc, 1'b0);
    check("rst_wr_data", bus.wr_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_stat", stat_burst_cnt, 16'd0);

    // 1) 0x1000, 16 DW: one 2-beat burst
    base = push_cnt;
    send(64'h1000, 10'd16, acc);
    wait_pushes(base + 1, "s1_pushes");
    check("s1_latency", push_cyc[base] - acc, 1);
    check("s1_desc_lit", push_data[base], {64'h1000, 8'd1, 3'd5, 2'b01});
    @(negedge CLK); #1;
    check("s1_ready_after", bus.req_ready, 1'b1);

    // 2) 0x0FF0, 8 DW: crosses a 4 KB page
    base = push_cnt;
    model_request(64'h0FF0, 8);
    check("s2_model_size", exp_q.size(), 2);
    exp_q.delete();
    send(64'h0FF0, 10'd8, acc);
    wait_pushes(base + 2, "s2_pushes");
    check("s2_desc0_lit", push_data[base],     {64'h0FF0, 8'd0, 3'd5, 2'b01});
    check("s2_desc1_lit", push_data[base + 1], {64'h1000, 8'd0, 3'd5, 2'b01});
    wait_idle("s2_idle");

    // 3) 0x2000, 1024 DW: eight capped bursts; a request while busy is ignored
    base = push_cnt;
    model_request(64'h2000, 0);
    check("s3_model_size", exp_q.size(), 8);
    exp_q.delete();
    send(64'h2000, 10'd0, acc);
    bus.req_addr  = 64'h5000;
    bus.req_len   = 10'd4;
    bus.req_valid = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("s3_ready_busy", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    wait_pushes(base + 8, "s3_pushes");
    for (int i = 1; i < 8; i++) check("s3_spacing", push_cyc[base + i] - push_cyc[base + i - 1], 2);
    check("s3_last_lit", push_data[base + 7], {64'h2E00, 8'd15, 3'd5, 2'b01});
    wait_idle("s3_idle");
    repeat (3) @(negedge CLK);
    #1;
    check("s3_no_extra", push_cnt, base + 8);
    check("stat_after_s123", stat_burst_cnt, STATS ? 16'd11 : 16'd0);

    // 4) same request with the FIFO full for 5 cycles during the 3rd PUSH
    base = push_cnt;
    send(64'h2000, 10'd0, acc);
    wait_pushes(base + 2, "s4_first_two");
    @(posedge CLK); #1;
    bus.wr_full = 1'b1;
    @(posedge CLK);
    repeat (5) begin
      @(negedge CLK);
      check("s4_stall_inc", bus.wr_inc, 1'b0);
      check("s4_stall_data", bus.wr_data, {64'h2400, 8'd15, 3'd5, 2'b01});
    end
    @(posedge CLK); #1;
    bus.wr_full = 1'b0;
    rel_cyc = cyc;
    wait_pushes(base + 8, "s4_pushes");
    check("s4_release_cycle", push_cyc[base + 2], rel_cyc);
    check("s4_third_lit", push_data[base + 2], {64'h2400, 8'd15, 3'd5, 2'b01});
    wait_idle("s4_idle");
    check("s4_model_drained", exp_q.size(), 0);

    // 5) reset one cycle after the first push; then a fresh request
    base = push_cnt;
    send(64'h2000, 10'd0, acc);
    wait_pushes(base + 1, "s5_first");
    @(posedge CLK); #1;
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    check("s5_busy", busy, 1'b0);
    check("s5_ready", bus.req_ready, 1'b1);
    check("s5_inc", bus.wr_inc, 1'b0);
    repeat (10) @(negedge CLK);
    #1;
    check("s5_abandoned", push_cnt, base + 1);
    send(64'h3000, 10'd4, acc);
    wait_pushes(base + 2, "s5_new_push");
    check("s5_new_lit", push_data[base + 1], {64'h3000, 8'd0, 3'd5, 2'b01});
    wait_idle("s5_idle");
    @(negedge CLK); #1;
    check("s5_stat", stat_burst_cnt, STATS ? 16'd1 : 16'd0);
    check("end_model_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_bridge_aw_splitter.md
Name: master_bridge_aw_splitter

Overview:
- Write-address splitter for the TL RX master bridge, directly upstream of the master bridge async FIFO write side.
- Takes one decoded memory-write request (start address plus DW length) and breaks it into AXI4 INCR write-address bursts.
- Bursts never cross a 4 KB boundary and never exceed MAX_BEATS beats.
- Each burst descriptor is pushed into the async FIFO through the wr_inc / wr_full interface.

Parameters:
- ADDR_WIDTH, 64, request/AXI address width.
- BEAT_BYTES_LOG2, 5, log2 of bytes per AXI data beat (32 B); drives axi_size.
- MAX_BEATS, 16, maximum beats per burst (1..256, power of two, ≤ 4096 >> BEAT_BYTES_LOG2).
- ENTRY_WIDTH, ADDR_WIDTH+13, FIFO entry width: {addr, len[7:0], size[2:0], burst[1:0]}.

Ports:
- CLK  in  1  single clock (master bridge write-side clock).
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  splitter can accept a request.
- req_addr  in  ADDR_WIDTH  start byte address, DW aligned (bits [1:0] = 0).
- req_len  in  10  length in DW; 0 encodes 1024.
- wr_full  in  1  async FIFO full.
- wr_inc  out  1  push strobe to async FIFO.
- wr_data  out  ENTRY_WIDTH  burst descriptor.
- busy  out  1  request in progress.
- stat_burst_cnt  out  16  bursts pushed (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, wr_inc=0, wr_data=0, busy=0, stat_burst_cnt=0.
- FSM IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch cur_addr=req_addr and end_addr=req_addr+(len_dw*4)-1, where len_dw=1024 when req_len=0.
  - Go to CALC.
- FSM CALC (req_ready=0):
  - bnd_end = {cur_addr[ADDR_WIDTH-1:12], 12'hFFF}.
  - cap_end = (((cur_addr>>L)+MAX_BEATS)<<L)-1, with L=BEAT_BYTES_LOG2.
  - seg_end = min(end_addr, bnd_end, cap_end).
  - beats = (seg_end>>L)-(cur_addr>>L)+1.
  - Register wr_data = {cur_addr, beats-1, L[2:0], 2'b01 (INCR)}.
  - Register last_seg=(seg_end==end_addr) and next_addr=seg_end+1.
  - Go to PUSH.
- FSM PUSH:
  - wr_inc = ~wr_full (combinational from state and wr_full).
  - wr_data stays stable until the push happens.
  - On push: if last_seg go to IDLE, else cur_addr<=next_addr and go to CALC.
- busy = (state != IDLE).
- Latency: request accepted at edge T; first wr_inc is possible in cycle T+2. Each burst costs 2 cycles when there is no backpressure. req_ready rises in the cycle after the last push.
- Arithmetic:
  - end_addr is computed in ADDR_WIDTH bits; wrap past the top of the address space is not supported (upstream guarantees it).
  - beats is always in 1..MAX_BEATS; len fits 8 bits.
- Boundaries:
  - wr_full held: stay in PUSH indefinitely, no state or data change.
  - wr_full deasserting in a cycle gives a push in that same cycle.
  - A 4 KB crossing and the MAX_BEATS cap can coincide; min() handles both.
  - req_valid while busy is ignored (req_ready=0).
- Reset mid-operation: the next edge with RST=1 forces IDLE and drops wr_inc. The partial request is abandoned with no further pushes.

Optional Feature:
- Macro: MB_AW_SPLIT_STATS_EN.
- Defined: stat_burst_cnt increments on every cycle with wr_inc=1 and saturates at 16'hFFFF. It is cleared only by RST.
- Undefined: the counter logic is not built and stat_burst_cnt is tied to 0.

Test Plan:
- addr 0x1000, len 16 (64 B) → one push: addr 0x1000, len 1, size 5, burst 01; req_ready high 1 cycle after the push.
- addr 0x0FF0, len 8 (32 B, crosses 4 KB) → two pushes: {0x0FF0, len 0} then {0x1000, len 0}.
- addr 0x2000, len 0 (4096 B) → 8 pushes, each len 15, addrs 0x2000, 0x2200, …, 0x2E00; pushes spaced 2 cycles apart.
- Same as previous with wr_full=1 for 5 cycles during the 3rd PUSH → wr_inc=0 and wr_data=0x2400 descriptor stable for 5 cycles, then exactly one push; total of 8 pushes preserved.
- Reset pulse 1 cycle after the 1st push of the 0x2000 request → IDLE, busy=0, req_ready=1 the next cycle, no further wr_inc. A new request {0x3000, len 4} then gives one push {0x3000, len 0}.
- With MB_AW_SPLIT_STATS_EN defined, run scenarios 1–3 → stat_burst_cnt=11. Without the macro → stat_burst_cnt stays 0.
